// File: rtl/cpu_disp_scan.sv
// Observation stage for the single-cycle CPU: snapshots PC/INST/R on each STEP and
// scans the button-selected word as eight hex digits on a multiplexed 7-segment display.
module cpu_disp_scan #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] PC,
  input  logic [31:0] INST,
  input  logic [31:0] R,
  input  logic        STEP,
  input  logic        SEL_BTN,
  output logic [7:0]  AN,
  output logic [7:0]  SEG,
  output logic [1:0]  SEL
);

  localparam int unsigned PS_W = $clog2(REFRESH_DIV);
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(REFRESH_DIV - 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    SEL_PC   = 2'd0,
    SEL_INST = 2'd1,
    SEL_R    = 2'd2
  } sel_e;

  logic [31:0]     r_snap_pc;
  logic [31:0]     r_snap_inst;
  logic [31:0]     r_snap_r;
  logic            r_sync0;
  logic            r_sync1;
  logic            r_stable;
  logic [DB_W-1:0] r_db_cnt;
  sel_e            r_sel;
  logic [PS_W-1:0] r_presc;
  logic [2:0]      r_idx;
  logic [7:0]      r_an;
  logic [7:0]      r_seg;

  logic [31:0]     w_word;
  logic [3:0]      w_nib;
  logic            w_dp_on;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    w_word = r_snap_r;
    case (r_sel)
      SEL_PC:   w_word = r_snap_pc;
      SEL_INST: w_word = r_snap_inst;
      default:  w_word = r_snap_r;
    endcase
    w_nib   = w_word[{r_idx, 2'b00} +: 4];
    w_dp_on = (r_idx == {1'b0, r_sel});
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_snap_pc   <= '0;
      r_snap_inst <= '0;
      r_snap_r    <= '0;
      r_sync0     <= 1'b0;
      r_sync1     <= 1'b0;
      r_stable    <= 1'b0;
      r_db_cnt    <= '0;
      r_sel       <= SEL_PC;
      r_presc     <= '0;
      r_idx       <= '0;
      r_an        <= '1;
      r_seg       <= '1;
    end else begin
      if (STEP) begin
        r_snap_pc   <= PC;
        r_snap_inst <= INST;
        r_snap_r    <= R;
      end

      r_sync0 <= SEL_BTN;
      r_sync1 <= r_sync0;

      // The selection advances on the same edge the stable level rises.
      if (r_sync1 != r_stable) begin
        if (r_db_cnt == DB_MAX) begin
          r_stable <= r_sync1;
          r_db_cnt <= '0;
          if (r_sync1) begin
            case (r_sel)
              SEL_PC:   r_sel <= SEL_INST;
              SEL_INST: r_sel <= SEL_R;
              default:  r_sel <= SEL_PC;
            endcase
          end
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end

      if (r_presc == PS_MAX) begin
        r_presc <= '0;
        r_idx   <= r_idx + 3'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      r_an  <= ~(8'h01 << r_idx);
      r_seg <= {~w_dp_on, hex7(w_nib)};
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;
  assign SEL = r_sel;

endmodule

// File: tb/tb_cpu_disp_scan.sv
// Directed bench for cpu_disp_scan with a scoreboard queue of expected values,
// using REFRESH_DIV=4 and DEBOUNCE_CYC=8.
module tb_cpu_disp_scan;

  localparam int unsigned RD = 4;
  localparam int unsigned DB = 8;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [31:0] PC = '0;
  logic [31:0] INST = '0;
  logic [31:0] R = '0;
  logic        STEP = 1'b0;
  logic        SEL_BTN = 1'b0;
  logic [7:0]  AN;
  logic [7:0]  SEG;
  logic [1:0]  SEL;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;
  exp_t sb[$];

  logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [31:0] sp = '0, si = '0, sr = '0;
  int cur_sel = 0;

  cpu_disp_scan #(.REFRESH_DIV(RD), .DEBOUNCE_CYC(DB)) dut (
    .CLK(CLK), .RSTn(RSTn), .PC(PC), .INST(INST), .R(R), .STEP(STEP),
    .SEL_BTN(SEL_BTN), .AN(AN), .SEG(SEG), .SEL(SEL)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [7:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [31:0] w, input int d, input int s);
    logic [7:0] v;
    v = HEX[w[d*4 +: 4]];
    if (d == s) v[7] = 1'b0;
    return v;
  endfunction

  function automatic logic [31:0] shown_word(input int s);
    return (s == 0) ? sp : (s == 1) ? si : sr;
  endfunction

  task automatic push_frame(input string tag);
    logic [31:0] w;
    w = shown_word(cur_sel);
    for (int d = 0; d < 8; d++)
      push($sformatf("%s_d%0d", tag, d), seg_of(w, d, cur_sel));
  endtask

  task automatic check_frame();
    logic [7:0] an_exp;
    bit found;
    exp_t e;
    for (int d = 0; d < 8; d++) begin
      an_exp = ~(8'h01 << d);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        @(negedge CLK);
        if (AN === an_exp) found = 1'b1;
      end
      if (found) begin
        check(SEG);
      end else begin
        total++;
        bad++;
        e = sb.pop_front();
        $error("FAIL %s_timeout observed=AN %h expected=AN %h", e.tag, AN, an_exp);
      end
    end
  endtask

  task automatic step(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] r);
    @(negedge CLK);
    PC = pc; INST = inst; R = r; STEP = 1'b1;
    sp = pc; si = inst; sr = r;
    @(negedge CLK);
    STEP = 1'b0;
  endtask

  // Button rises after a negedge; the new SEL must appear exactly at the 10th edge.
  task automatic press(input string tag);
    @(negedge CLK);
    SEL_BTN = 1'b1;
    push({tag, "_pre"}, 8'(cur_sel));
    repeat (DB + 1) @(negedge CLK);
    check({6'b0, SEL});
    cur_sel = (cur_sel + 1) % 3;
    push({tag, "_post"}, 8'(cur_sel));
    @(negedge CLK);
    check({6'b0, SEL});
    SEL_BTN = 1'b0;
    push({tag, "_held"}, 8'(cur_sel));
    repeat (DB + 4) @(negedge CLK);
    check({6'b0, SEL});
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    push("rst_an", 8'hFF);  check(AN);
    push("rst_seg", 8'hFF); check(SEG);
    push("rst_sel", 8'h00); check({6'b0, SEL});
    RSTn = 1'b1;

    // Dwell: each digit enable held RD cycles, wrapping 7 -> 0.
    for (int k = 1; k <= 8 * RD + 4; k++) begin
      @(negedge CLK);
      push($sformatf("dwell_an_%0d", k), ~(8'h01 << (((k - 1) / RD) % 8)));
      check(AN);
      if (k == 1) begin
        push("first_seg", 8'h40);
        check(SEG);
      end
    end

    step(32'h0040_001C, 32'h0, 32'h0);
    push_frame("pc");
    check_frame();

    step(32'h0040_001C, 32'h1234_ABCD, 32'h0);
    press("press1");
    push_frame("inst");
    check_frame();

    // Bounce: 14 toggles every 3 cycles, ending low, then a clean final rise.
    for (int t = 0; t < 14; t++) begin
      @(negedge CLK);
      SEL_BTN = ~SEL_BTN;
      repeat (2) @(negedge CLK);
    end
    push("bounce_hold", 8'(cur_sel));
    check({6'b0, SEL});
    press("bounce_rise");

    step(32'h0040_001C, 32'h1234_ABCD, 32'hFFFF_FFFF);
    push_frame("r");
    check_frame();

    press("p_wrap");
    press("p_inst");
    press("p_r");

    // Reset lands while the debounce counter holds 5.
    @(negedge CLK);
    SEL_BTN = 1'b1;
    repeat (7) @(negedge CLK);
    RSTn = 1'b0;
    @(negedge CLK);
    push("mid_rst_an", 8'hFF);  check(AN);
    push("mid_rst_seg", 8'hFF); check(SEG);
    push("mid_rst_sel", 8'h00); check({6'b0, SEL});
    RSTn = 1'b1;
    cur_sel = 0; sp = '0; si = '0; sr = '0;
    @(negedge CLK);
    push("rel_an", 8'hFE);  check(AN);
    push("rel_seg", 8'h40); check(SEG);
    repeat (DB) @(negedge CLK);
    push("rel_sel_pre", 8'h00); check({6'b0, SEL});
    @(negedge CLK);
    cur_sel = 1;
    push("rel_sel_post", 8'h01); check({6'b0, SEL});
    SEL_BTN = 1'b0;
    repeat (DB + 4) @(negedge CLK);

    // STEP held high: snapshot follows the inputs every cycle.
    @(negedge CLK);
    STEP = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      PC = 32'h0; INST = {8{4'(n)}}; R = 32'h0;
      @(negedge CLK);
    end
    STEP = 1'b0;
    INST = 32'hFFFF_FFFF;
    sp = 32'h0; si = 32'h3333_3333; sr = 32'h0;
    push_frame("held");
    check_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
